// File: rtl/hazard_scoreboard_pkg.sv
// Shared types, constants and parameter checks for the DLX hazard scoreboard.
package hazard_pkg;

   // Widest register index an entry can hold; narrower indices are zero-extended.
   localparam int unsigned MAX_REGW = 16;
   // Latency field width; covers 1 + LOAD_LAT for every legal depth.
   localparam int unsigned LATW = 4;
   // Select code for the EX-stage combinational ALU output.
   localparam int unsigned FSEL_ALU_EX = 0;

   // One in-flight writer, held per post-ID stage.
   typedef struct packed {
      logic                v;
      logic                wr;
      logic [MAX_REGW-1:0] rd;
      logic [LATW-1:0]     lat;
   } entry_t;

   // Width of every forward-select port: codes 0..DEPTH.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Select code for the register file (write-through), always the last code.
   function automatic int fsel_rf(input int depth);
      return depth;
   endfunction

   // Legal parameter combinations for the scoreboard.
   function automatic bit params_legal(input int depth, input int load_lat,
                                       input int regw, input int cntw);
      return (depth >= 2) && (depth <= 8) && (load_lat >= 0) &&
             ((1 + load_lat) <= (depth - 1)) && (regw >= 1) &&
             (regw <= int'(MAX_REGW)) && (cntw >= 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request, freeze and forwarding/stall response bundle between core and scoreboard.
interface hazard_scoreboard_if #(
   parameter int DEPTH = 3,
   parameter int REGW  = 5,
   parameter int CNTW  = 16
);
   localparam int SELW = hazard_pkg::sel_width(DEPTH);

   logic            id_valid;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic            id_use_rs1;
   logic            id_use_rs2;
   logic            id_rs1_early;
   logic            id_wr;
   logic [REGW-1:0] id_rd;
   logic            id_load;
   logic            id_kill;
   logic            mem_busy;

   logic            stall;
   logic [SELW-1:0] id_rs1_fsel;
   logic [SELW-1:0] ex_rs1_fsel;
   logic [SELW-1:0] ex_rs2_fsel;
   logic            ex_valid;
   logic [CNTW-1:0] stall_count;

   // Core side: issues the ID instruction, consumes selects and stall.
   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_early,
             id_wr, id_rd, id_load, id_kill, mem_busy,
      input  stall, id_rs1_fsel, ex_rs1_fsel, ex_rs2_fsel, ex_valid, stall_count
   );

   // Scoreboard side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_early,
             id_wr, id_rd, id_load, id_kill, mem_busy,
      output stall, id_rs1_fsel, ex_rs1_fsel, ex_rs2_fsel, ex_valid, stall_count
   );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-writer priority encoder: finds the newest in-flight entry that writes src.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int REGW     = 5,
   parameter int ZERO_REG = 1,
   parameter int KW       = 2
) (
   input  entry_t          entries [DEPTH],
   input  logic [REGW-1:0] src,
   output logic            hit,
   output logic [KW-1:0]   k,
   output logic [LATW-1:0] lat
);

   logic [DEPTH-1:0] match_s;
   logic             src_blocked_s;

   // Per-entry match; register 0 is never a dependency when ZERO_REG is set.
   always_comb begin
      match_s       = '0;
      src_blocked_s = (ZERO_REG != 0) && (src == '0);
      for (int i = 0; i < DEPTH; i++) begin
         match_s[i] = entries[i].v && entries[i].wr &&
                      (entries[i].rd == MAX_REGW'(src)) && !src_blocked_s;
      end
   end

   // Scan oldest to youngest so the smallest stage index overwrites the rest.
   always_comb begin
      hit = 1'b0;
      k   = '0;
      lat = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         hit = hit | match_s[i];
         k   = match_s[i] ? KW'(i) : k;
         lat = match_s[i] ? entries[i].lat : lat;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight writers driving operand forwarding, stall and bubble count.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int REGW     = 5,
   parameter int ZERO_REG = 1,
   parameter int CNTW     = 16
) (
   input logic              clk,
   input logic              reset,
   hazard_scoreboard_if.slave bus
);

   localparam int              SELW     = sel_width(DEPTH);
   localparam logic [SELW-1:0] SEL_RF   = SELW'(fsel_rf(DEPTH));
   localparam logic [SELW-1:0] SEL_EX   = SELW'(FSEL_ALU_EX);
   localparam logic [LATW-1:0] LAT_ALU  = LATW'(1);
   localparam logic [LATW-1:0] LAT_LOAD = LATW'(1 + LOAD_LAT);

   generate
      if (!params_legal(DEPTH, LOAD_LAT, REGW, CNTW)) begin : g_bad_params
         $error("hazard_scoreboard: illegal DEPTH/LOAD_LAT/REGW/CNTW combination");
      end
   endgenerate

   // Stage k of the post-ID pipeline: 0 = EX ... DEPTH-1 = WB.
   entry_t          entries_r [DEPTH];
   logic            ex_valid_r;
   logic [SELW-1:0] ex_rs1_fsel_r;
   logic [SELW-1:0] ex_rs2_fsel_r;
   logic [CNTW-1:0] stall_count_r;

   logic            m_id_hit_s,  m_rs1_hit_s,  m_rs2_hit_s;
   logic [SELW-1:0] m_id_k_s,    m_rs1_k_s,    m_rs2_k_s;
   logic [LATW-1:0] m_id_lat_s,  m_rs1_lat_s,  m_rs2_lat_s;

   logic            early_ok_s;
   logic            early_haz_s;
   logic            rs1_haz_s;
   logic            rs2_haz_s;
   logic            stall_s;
   logic            insert_s;
   logic [SELW-1:0] id_rs1_fsel_s;
   entry_t          new_entry_s;
   logic [SELW-1:0] ex_rs1_nxt_s;
   logic [SELW-1:0] ex_rs2_nxt_s;

   hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .ZERO_REG(ZERO_REG), .KW(SELW)) u_match_id (
      .entries (entries_r),
      .src     (bus.id_rs1),
      .hit     (m_id_hit_s),
      .k       (m_id_k_s),
      .lat     (m_id_lat_s)
   );

   hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .ZERO_REG(ZERO_REG), .KW(SELW)) u_match_rs1 (
      .entries (entries_r),
      .src     (bus.id_rs1),
      .hit     (m_rs1_hit_s),
      .k       (m_rs1_k_s),
      .lat     (m_rs1_lat_s)
   );

   hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .ZERO_REG(ZERO_REG), .KW(SELW)) u_match_rs2 (
      .entries (entries_r),
      .src     (bus.id_rs2),
      .hit     (m_rs2_hit_s),
      .k       (m_rs2_k_s),
      .lat     (m_rs2_lat_s)
   );

   // Hazard detection: EX operands need the result one stage later, ID early rs1 needs it now.
   always_comb begin
      // An ALU producer still in EX can feed ID straight from the EX ALU output.
      early_ok_s  = (int'(m_id_k_s) >= int'(m_id_lat_s)) ||
                    ((m_id_k_s == SEL_EX) && (m_id_lat_s == LAT_ALU));
      early_haz_s = bus.id_rs1_early && m_id_hit_s && !early_ok_s;
      rs1_haz_s   = bus.id_use_rs1 && m_rs1_hit_s &&
                    ((int'(m_rs1_k_s) + 1) < int'(m_rs1_lat_s));
      rs2_haz_s   = bus.id_use_rs2 && m_rs2_hit_s &&
                    ((int'(m_rs2_k_s) + 1) < int'(m_rs2_lat_s));
      // The core freezes itself on mem_busy, so no stall is reported then.
      stall_s     = bus.id_valid && !bus.id_kill &&
                    (early_haz_s || rs1_haz_s || rs2_haz_s) && !bus.mem_busy;
      insert_s    = bus.id_valid && !bus.id_kill && !stall_s;
      id_rs1_fsel_s = m_id_hit_s ? m_id_k_s : SEL_RF;
   end

   // Next stage-0 entry and EX selects; a producer at stage k is one stage further
   // on once this instruction reaches EX, and k+1 == DEPTH lands on the register file.
   always_comb begin
      new_entry_s  = '0;
      ex_rs1_nxt_s = SEL_RF;
      ex_rs2_nxt_s = SEL_RF;
      if (insert_s) begin
         new_entry_s.v   = 1'b1;
         new_entry_s.wr  = bus.id_wr;
         new_entry_s.rd  = MAX_REGW'(bus.id_rd);
         new_entry_s.lat = bus.id_load ? LAT_LOAD : LAT_ALU;
         ex_rs1_nxt_s    = m_rs1_hit_s ? SELW'(int'(m_rs1_k_s) + 1) : SEL_RF;
         ex_rs2_nxt_s    = m_rs2_hit_s ? SELW'(int'(m_rs2_k_s) + 1) : SEL_RF;
      end else begin
         new_entry_s  = '0;
         ex_rs1_nxt_s = SEL_RF;
         ex_rs2_nxt_s = SEL_RF;
      end
   end

   // Advance the writer pipeline on the core's stage-register edge; freeze holds everything.
   always_ff @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= '0;
         end
         ex_valid_r    <= 1'b0;
         ex_rs1_fsel_r <= SEL_RF;
         ex_rs2_fsel_r <= SEL_RF;
      end else if (!bus.mem_busy) begin
         entries_r[0] <= new_entry_s;
         for (int i = 1; i < DEPTH; i++) begin
            entries_r[i] <= entries_r[i-1];
         end
         ex_valid_r    <= insert_s;
         ex_rs1_fsel_r <= ex_rs1_nxt_s;
         ex_rs2_fsel_r <= ex_rs2_nxt_s;
      end else begin
         ex_valid_r    <= ex_valid_r;
         ex_rs1_fsel_r <= ex_rs1_fsel_r;
         ex_rs2_fsel_r <= ex_rs2_fsel_r;
      end
   end

   // Saturating count of inserted bubbles caused by hazards.
   always_ff @(negedge clk) begin
      if (reset) begin
         stall_count_r <= '0;
      end else if (stall_s && (stall_count_r != {CNTW{1'b1}})) begin
         stall_count_r <= stall_count_r + CNTW'(1);
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign bus.stall       = stall_s;
   assign bus.id_rs1_fsel = id_rs1_fsel_s;
   assign bus.ex_rs1_fsel = ex_rs1_fsel_r;
   assign bus.ex_rs2_fsel = ex_rs2_fsel_r;
   assign bus.ex_valid    = ex_valid_r;
   assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default scoreboard, a ZERO_REG=0 copy and a 2-bit counter copy share stimulus.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_rs1_early, id_wr, id_load, id_kill, mem_busy;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [22:0] in_vec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.DEPTH(3), .REGW(5), .CNTW(16)) bus_a ();
   hazard_scoreboard_if #(.DEPTH(3), .REGW(5), .CNTW(16)) bus_b ();
   hazard_scoreboard_if #(.DEPTH(3), .REGW(5), .CNTW(2))  bus_c ();

   assign in_vec = {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_early,
                    id_wr, id_rd, id_load, id_kill, mem_busy};
   assign {bus_a.id_valid, bus_a.id_rs1, bus_a.id_rs2, bus_a.id_use_rs1, bus_a.id_use_rs2,
           bus_a.id_rs1_early, bus_a.id_wr, bus_a.id_rd, bus_a.id_load, bus_a.id_kill,
           bus_a.mem_busy} = in_vec;
   assign {bus_b.id_valid, bus_b.id_rs1, bus_b.id_rs2, bus_b.id_use_rs1, bus_b.id_use_rs2,
           bus_b.id_rs1_early, bus_b.id_wr, bus_b.id_rd, bus_b.id_load, bus_b.id_kill,
           bus_b.mem_busy} = in_vec;
   assign {bus_c.id_valid, bus_c.id_rs1, bus_c.id_rs2, bus_c.id_use_rs1, bus_c.id_use_rs2,
           bus_c.id_rs1_early, bus_c.id_wr, bus_c.id_rd, bus_c.id_load, bus_c.id_kill,
           bus_c.mem_busy} = in_vec;

   hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .REGW(5), .ZERO_REG(1), .CNTW(16)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .REGW(5), .ZERO_REG(0), .CNTW(16)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));
   hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .REGW(5), .ZERO_REG(1), .CNTW(2)) dut_c (
      .clk(clk), .reset(reset), .bus(bus_c));

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One state-advancing negedge, then sample 1 time unit after the following posedge.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic e, input logic w,
                      input logic [4:0] d, input logic ld);
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rs1_early = e; id_wr = w; id_rd = d; id_load = ld;
      id_kill = 1'b0; mem_busy = 1'b0;
      #1;
   endtask

   task automatic nop();                                    put(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); endtask
   task automatic alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b); put(1'b1, a, b, 1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0); endtask
   task automatic lw(input logic [4:0] d, input logic [4:0] a);  put(1'b1, a, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, d, 1'b1); endtask
   task automatic beqz(input logic [4:0] a);                 put(1'b1, a, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0); endtask

   initial begin
      reset = 1'b1;
      nop();
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      chk("rst_ex_rs1",   32'(bus_a.ex_rs1_fsel), 32'd3);
      chk("rst_ex_rs2",   32'(bus_a.ex_rs2_fsel), 32'd3);
      chk("rst_count",    32'(bus_a.stall_count), 32'd0);
      chk("rst_count_c",  32'(bus_c.stall_count), 32'd0);

      // ALU chain: back-to-back dependency forwards from stage 1
      alu(5'd3, 5'd1, 5'd2);
      chk("alu1_stall", 32'(bus_a.stall), 32'd0);
      tick();
      chk("alu1_ex_valid", 32'(bus_a.ex_valid), 32'd1);
      chk("alu1_ex_rs1",   32'(bus_a.ex_rs1_fsel), 32'd3);
      alu(5'd4, 5'd3, 5'd3);
      chk("alu2_stall", 32'(bus_a.stall), 32'd0);
      tick();
      chk("alu2_ex_rs1", 32'(bus_a.ex_rs1_fsel), 32'd1);
      chk("alu2_ex_rs2", 32'(bus_a.ex_rs2_fsel), 32'd1);
      alu(5'd8, 5'd9, 5'd10);
      tick();
      chk("alu3_ex_rs1", 32'(bus_a.ex_rs1_fsel), 32'd3);
      chk("alu3_ex_rs2", 32'(bus_a.ex_rs2_fsel), 32'd3);

      // Load-use: one bubble, then the load result comes off stage 2
      lw(5'd5, 5'd1);
      tick();
      alu(5'd6, 5'd5, 5'd1);
      chk("lu_stall", 32'(bus_a.stall), 32'd1);
      tick();
      chk("lu_count",    32'(bus_a.stall_count), 32'd1);
      chk("lu_bubble",   32'(bus_a.ex_valid), 32'd0);
      chk("lu_stall_2",  32'(bus_a.stall), 32'd0);
      tick();
      chk("lu_ex_rs1",   32'(bus_a.ex_rs1_fsel), 32'd2);
      chk("lu_ex_rs2",   32'(bus_a.ex_rs2_fsel), 32'd3);
      chk("lu_ex_valid", 32'(bus_a.ex_valid), 32'd1);

      // Branch after ALU forwards from EX; branch after load waits two cycles
      alu(5'd7, 5'd1, 5'd2);
      tick();
      beqz(5'd7);
      chk("br_alu_fsel",  32'(bus_a.id_rs1_fsel), 32'd0);
      chk("br_alu_stall", 32'(bus_a.stall), 32'd0);
      tick();
      lw(5'd7, 5'd1);
      tick();
      beqz(5'd7);
      chk("br_lw_stall1", 32'(bus_a.stall), 32'd1);
      tick();
      chk("br_lw_stall2", 32'(bus_a.stall), 32'd1);
      tick();
      chk("br_lw_stall3", 32'(bus_a.stall), 32'd0);
      chk("br_lw_fsel",   32'(bus_a.id_rs1_fsel), 32'd2);
      chk("br_lw_count",  32'(bus_a.stall_count), 32'd3);
      tick();

      // Register 0: ignored with ZERO_REG=1, a real hazard with ZERO_REG=0
      lw(5'd0, 5'd1);
      tick();
      alu(5'd13, 5'd0, 5'd0);
      chk("z_stall_a", 32'(bus_a.stall), 32'd0);
      chk("z_stall_b", 32'(bus_b.stall), 32'd1);
      tick();
      chk("z_ex_rs1_a", 32'(bus_a.ex_rs1_fsel), 32'd3);
      chk("z_ex_rs2_a", 32'(bus_a.ex_rs2_fsel), 32'd3);
      chk("z_stall_b2", 32'(bus_b.stall), 32'd0);
      chk("z_count_b",  32'(bus_b.stall_count), 32'd4);

      // Saturation: fourth stall leaves the 2-bit counter at 3
      lw(5'd11, 5'd2);
      tick();
      alu(5'd12, 5'd11, 5'd11);
      chk("sat_stall", 32'(bus_a.stall), 32'd1);
      tick();
      chk("sat_count_a", 32'(bus_a.stall_count), 32'd4);
      chk("sat_count_c", 32'(bus_c.stall_count), 32'd3);

      // Kill beats stall
      reset = 1'b1;
      nop();
      tick();
      reset = 1'b0;
      chk("rst2_count", 32'(bus_a.stall_count), 32'd0);
      lw(5'd5, 5'd1);
      tick();
      alu(5'd6, 5'd5, 5'd1);
      id_kill = 1'b1;
      #1;
      chk("kill_stall", 32'(bus_a.stall), 32'd0);
      tick();
      chk("kill_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      chk("kill_count",    32'(bus_a.stall_count), 32'd0);

      // Freeze in the middle of a load-use
      lw(5'd9, 5'd1);
      tick();
      chk("fz_lw_valid", 32'(bus_a.ex_valid), 32'd1);
      alu(5'd10, 5'd9, 5'd1);
      chk("fz_pre_stall", 32'(bus_a.stall), 32'd1);
      mem_busy = 1'b1;
      #1;
      chk("fz_busy_stall", 32'(bus_a.stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fz_ex_valid", 32'(bus_a.ex_valid), 32'd1);
         chk("fz_count",    32'(bus_a.stall_count), 32'd0);
         chk("fz_ex_rs1",   32'(bus_a.ex_rs1_fsel), 32'd3);
      end
      mem_busy = 1'b0;
      #1;
      chk("fz_resume_stall", 32'(bus_a.stall), 32'd1);
      tick();
      chk("fz_count2",   32'(bus_a.stall_count), 32'd1);
      chk("fz_bubble",   32'(bus_a.ex_valid), 32'd0);
      tick();
      chk("fz_ex_rs1_2", 32'(bus_a.ex_rs1_fsel), 32'd2);
      chk("fz_ex_valid2", 32'(bus_a.ex_valid), 32'd1);

      // Reset with a load in EX, asserted together with mem_busy
      lw(5'd5, 5'd1);
      tick();
      alu(5'd6, 5'd5, 5'd1);
      reset = 1'b1;
      mem_busy = 1'b1;
      tick();
      reset = 1'b0;
      mem_busy = 1'b0;
      #1;
      chk("rst3_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      chk("rst3_count",    32'(bus_a.stall_count), 32'd0);
      chk("rst3_stall",    32'(bus_a.stall), 32'd0);
      tick();
      chk("rst3_ex_rs1",   32'(bus_a.ex_rs1_fsel), 32'd3);
      chk("rst3_ex_valid2", 32'(bus_a.ex_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard, forwarding and stall controller for the pipelined DLX core.
- Replaces the fixed EX/MEM/WB compare logic with a scoreboard of in-flight writers, one entry per post-ID stage.
- Computes the ID-stage early-operand forward select (branch/jump register), the registered EX operand forward selects, the stall signal and a bubble count.
- Supports configurable post-ID depth, configurable load latency and a global memory freeze.

Parameters:
- DEPTH, 3: number of post-ID stages tracked (stage 0 = EX ... DEPTH-1 = WB); legal range 2..8.
- LOAD_LAT, 1: extra cycles a load result needs beyond an ALU result; requires 1+LOAD_LAT <= DEPTH-1.
- REGW, 5: register index width.
- ZERO_REG, 1: when 1, register 0 never creates a hazard or a forward.
- CNTW, 16: width of the stall counter.

Ports:
- clk, in, 1: clock; everything samples on negedge clk, matching the core's stage registers.
- reset, in, 1: synchronous, active-high.
- id_valid, in, 1: the ID instruction is real (not a bubble or killed slot).
- id_rs1, in, REGW: source 1 index.
- id_rs2, in, REGW: source 2 index.
- id_use_rs1, in, 1: instruction reads rs1 in EX.
- id_use_rs2, in, 1: instruction reads rs2 in EX.
- id_rs1_early, in, 1: instruction needs rs1 in ID (branch or jump-register).
- id_wr, in, 1: instruction writes a register.
- id_rd, in, REGW: destination register.
- id_load, in, 1: instruction is a load (lw or lb).
- id_kill, in, 1: flush the ID slot (delay-slot kill).
- mem_busy, in, 1: freeze the whole pipeline this cycle.
- stall, out, 1: hold PC and IF/ID; a bubble enters EX.
- id_rs1_fsel, out, clog2(DEPTH+1): combinational select for the ID rs1 value.
- ex_rs1_fsel, out, clog2(DEPTH+1): registered select for the EX rs1 value.
- ex_rs2_fsel, out, clog2(DEPTH+1): registered select for the EX rs2 value.
- ex_valid, out, 1: the EX slot holds a real instruction.
- stall_count, out, CNTW: saturating count of bubbles inserted.

Behaviour:
- Select encoding (all fsel ports):
  - 0 = EX combinational ALU output.
  - j (1..DEPTH-1) = result bus at the input register of stage j; the core muxes ALU or memory data.
  - DEPTH = register file (write-through).
- Entry k holds {v, wr, rd, lat} for the instruction in stage k.
  - lat = 1 for an ALU writer, 1+LOAD_LAT for a load.
  - The result is on bus j when the entry sits at stage j and j >= lat.
- A producer matches a source when: v && wr && rd == src && src != 0 (the src != 0 term applies only if ZERO_REG).
  - The youngest match (smallest k) wins.
  - No match: select = DEPTH.
- EX operand (use_rsN set), producer at stage k:
  - OK if k+1 >= lat; registered select = k+1 (k+1 > DEPTH-1 means retired, select = DEPTH).
  - Otherwise hazard.
- ID early rs1 (id_rs1_early), producer at stage k:
  - OK if k >= lat (select k).
  - OK if k == 0 with lat == 1 (select 0).
  - Otherwise hazard.
  - id_rs1_fsel is driven combinationally every cycle.
- stall = id_valid && !id_kill && any hazard && !mem_busy.
- Each clock edge with mem_busy = 0:
  - Entries shift k -> k+1; entry DEPTH-1 retires.
  - Entry 0 loads the ID instruction if id_valid && !id_kill && !stall; otherwise it loads a bubble (v = 0).
  - ex_rs*_fsel and ex_valid load alongside entry 0. A bubble loads select DEPTH.
  - Registered selects age with the pipeline: each cycle the producer advances, but the selects only describe EX, so no later update is needed.
- mem_busy = 1: all entries, selects, ex_valid and stall_count hold; stall reads 0 (the core freezes separately).
- stall_count increments each cycle stall = 1 and saturates at all-ones.
- Simultaneous stall and id_kill: kill wins, no stall, bubble inserted.
- Reset values: all entry v = 0, ex_valid = 0, ex selects = DEPTH, stall_count = 0, stall = 0.
  - Reset mid-operation discards in-flight entries immediately.
  - Reset has priority over mem_busy.

Decomposition:
- Package hazard_pkg holds:
  - The entry struct {v, wr, rd, lat}.
  - The select width function clog2(DEPTH+1).
  - The FSEL_ALU_EX = 0 and FSEL_RF = DEPTH constants.
  - The parameter legality checks.
- Sub-module hazard_match: a combinational youngest-match priority encoder over the entries for one source index, returning {hit, k, lat}. It is instantiated three times (ID rs1 early, EX rs1, EX rs2).

Test Plan (DEPTH=3, LOAD_LAT=1):
- ALU chain: add r3 then add r4,r3,r3 back-to-back -> no stall; ex_rs1_fsel = ex_rs2_fsel = 1; the next unrelated instruction gets select 3.
- Load-use: lw r5 then add r6,r5,r1 -> stall = 1 for one cycle, stall_count = 1; then ex_rs1_fsel = 2, ex_rs2_fsel = 3.
- Branch after ALU: add r7 then beqz r7 -> id_rs1_fsel = 0, no stall. Branch directly after lw r7 -> stall for 2 cycles, then id_rs1_fsel = 2.
- Zero register: lw r0 then add r1,r0,r0 -> no stall, selects = 3. With ZERO_REG = 0 the same sequence stalls for one cycle.
- Kill and freeze: a hazard coincident with id_kill -> stall = 0, ex_valid = 0. mem_busy held 3 cycles mid load-use -> entries and stall_count unchanged, then the sequence resumes.
- Reset with a load in stage 0 -> next cycle ex_valid = 0, no stall on a dependent instruction, stall_count = 0. Counter forced near saturation (CNTW = 2) -> holds at 3.
